inst_seq_constraint: RTL and testbench
======================================

Name: inst_seq_constraint

Overview:
- Parametrised successor of the single-slot instruction-legality constraint for RIDECORE formal checking.
- Constrains an NSLOT-wide fetch group every cycle to the legal RV32IM subset, with optional register-index bounds for QED mode.
- Adds a sequencer: admits at most MAX_INST real instructions, then forces a NOP drain of DRAIN_CYC cycles, then holds NOPs.
- Output assume_ok is wrapped by the formal harness in an assume; it sits beside the fetch stage.

Parameters:
NSLOT, 2, fetch group width (1..4); slot 0 is the oldest.
MAX_INST, 1, non-NOP instructions admitted per sequence (1..255).
DRAIN_CYC, 16, NOP-only cycles after the last admitted instruction (1..256).
REG_LIMIT, 32, register indices used must be < REG_LIMIT (16 for QED, 32 for single-instruction checking).
EN_MUL, 1, admit MUL/MULH/MULHSU/MULHU.
EN_MEM, 1, admit LW/SW.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instruction  in  32*NSLOT  fetch group; slot i at [32*i+31:32*i]
inst_accept  in  1  core consumes the group this cycle (not stalled)
slot_legal  out  NSLOT  per-slot decode legal (ISA subset plus register bound)
slot_nop  out  NSLOT  per-slot opcode == 7'b1111111
assume_ok  out  1  combined constraint for the harness to assume
state  out  2  0=ISSUE, 1=DRAIN, 2=DONE
inst_count  out  8  instructions admitted so far
drain_cnt  out  8  drain cycles elapsed
seq_done  out  1  state==DONE
viol_seen  out  1  sticky: assume_ok was low while reset was low

Behaviour:
- Decode is combinational per slot.
  - R-type, opcode 0110011: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, funct7 exactly per RV32I. The MUL group (funct7 0000001, funct3 000..011) is legal only if EN_MUL.
  - I-type, opcode 0010011: ADDI/SLTI/SLTIU/XORI/ORI/ANDI with any immediate. SLLI/SRLI require funct7 0000000; SRAI requires funct7 0100000.
  - LW (0000011/010) and SW (0100011/010) are legal only if EN_MEM.
  - NOP (opcode 7F) is always legal. Everything else is illegal.
- Register bound, applied to fields actually used: R uses rd,rs1,rs2; I and LW use rd,rs1; SW uses rs1,rs2. Each must be < REG_LIMIT; NOP is exempt.
- k = popcount of non-NOP slots in the current group.
- Ordering rule: a non-NOP slot must not sit above a NOP slot (NOPs only fill the youngest slots).
- assume_ok by state:
  - ISSUE: all slots legal, ordering rule holds, and inst_count + k <= MAX_INST.
  - DRAIN and DONE: all slots NOP.
  - Forced 1 while reset is high.
- ISSUE: on inst_accept, inst_count <= min(inst_count + k, MAX_INST). If the updated count == MAX_INST, go to DRAIN with drain_cnt = 0. With inst_accept low, nothing changes.
- DRAIN: drain_cnt increments every cycle regardless of inst_accept. When drain_cnt == DRAIN_CYC-1, go to DONE (drain_cnt holds).
- DONE: absorbing until reset; seq_done = 1.
- viol_seen sets on any cycle with reset low and assume_ok low; it clears only on reset.
- Reset values: state=ISSUE, inst_count=0, drain_cnt=0, seq_done=0, viol_seen=0. Reset mid-sequence restarts from ISSUE.
- slot_legal and slot_nop are purely combinational and independent of reset and state.

Test Plan:
- NSLOT=2, MAX_INST=1. After reset, group {slot0=0x003100B3 ADD x1,x2,x3; slot1=0x0000007F}, accept=1 -> assume_ok=1, slot_legal=2'b11. Next cycle state=DRAIN, inst_count=1.
- DRAIN_CYC=4: drive NOPs -> state=DONE exactly 4 cycles after entering DRAIN, seq_done=1. One 0x00100293 (ADDI) in DONE -> assume_ok=0, viol_seen=1 next cycle.
- Illegal encodings:
  - 0x403110B3 (SLL with funct7 0100000) -> slot_legal[0]=0.
  - 0x023100B3 (MUL) with EN_MUL=0 -> slot_legal[0]=0; with EN_MUL=1 -> slot_legal[0]=1.
  - 0x00002083 (LW) with EN_MEM=0 -> slot_legal[0]=0.
- REG_LIMIT=16: 0x00310A33 (ADD x20,x2,x3) -> slot_legal=0. REG_LIMIT=32, same word -> slot_legal=1.
- MAX_INST=3, two ADDs with accept=0 for 2 cycles -> inst_count stays 0.
  - Then accept=1 -> inst_count=2.
  - Next group of two ADDs -> assume_ok=0, inst_count saturates at 3, state=DRAIN.
  - Group {NOP, ADD} -> ordering violation, assume_ok=0.
- Assert reset in DRAIN with drain_cnt=2 -> next cycle state=ISSUE, counters=0, viol_seen=0, assume_ok=1 during reset.

Source files
------------

// File: rtl/inst_seq_constraint.sv
// Fetch-group legality constraint for formal checking of the core.
// Decodes an NSLOT-wide group against the RV32IM subset and sequences issue, NOP drain and hold.
module inst_seq_constraint #(
  parameter int unsigned NSLOT     = 2,
  parameter int unsigned MAX_INST  = 1,
  parameter int unsigned DRAIN_CYC = 16,
  parameter int unsigned REG_LIMIT = 32,
  parameter bit          EN_MUL    = 1'b1,
  parameter bit          EN_MEM    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32*NSLOT-1:0]   instruction,
  input  logic                  inst_accept,
  output logic [NSLOT-1:0]      slot_legal,
  output logic [NSLOT-1:0]      slot_nop,
  output logic                  assume_ok,
  output logic [1:0]            state,
  output logic [7:0]            inst_count,
  output logic [7:0]            drain_cnt,
  output logic                  seq_done,
  output logic                  viol_seen
);

  localparam int unsigned CW = 8;
  localparam int unsigned KW = 3;
  localparam int unsigned SW = 9;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_NOP = 7'b1111111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } st_t;

  st_t st_q;

  function automatic logic reg_ok(input logic [4:0] idx);
    return 32'(idx) < REG_LIMIT;
  endfunction

  // ISA subset plus register bound on the fields the instruction actually reads or writes
  function automatic logic decode_legal(input logic [31:0] w);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ok;
    op  = w[6:0];
    rd  = w[11:7];
    f3  = w[14:12];
    rs1 = w[19:15];
    rs2 = w[24:20];
    f7  = w[31:25];
    ok  = 1'b0;
    case (op)
      OP_R: begin
        case (f7)
          F7_BASE: ok = 1'b1;
          F7_ALT:  ok = (f3 == 3'b000) || (f3 == 3'b101);
          F7_MUL:  ok = EN_MUL && !f3[2];
          default: ok = 1'b0;
        endcase
        ok = ok && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
      end
      OP_I: begin
        case (f3)
          3'b001:  ok = (f7 == F7_BASE);
          3'b101:  ok = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: ok = 1'b1;
        endcase
        ok = ok && reg_ok(rd) && reg_ok(rs1);
      end
      OP_LD:   ok = EN_MEM && (f3 == 3'b010) && reg_ok(rd) && reg_ok(rs1);
      OP_ST:   ok = EN_MEM && (f3 == 3'b010) && reg_ok(rs1) && reg_ok(rs2);
      OP_NOP:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign slot_nop[i]   = (instruction[32*i +: 7] == OP_NOP);
    assign slot_legal[i] = decode_legal(instruction[32*i +: 32]);
  end

  logic [KW-1:0] k_c;
  logic          order_ok_c;
  logic [SW-1:0] sum_c;
  logic          fits_c;
  logic [CW-1:0] next_cnt_c;

  // Group summary: real-instruction count and NOPs packed into the youngest slots
  always_comb begin
    k_c        = '0;
    order_ok_c = 1'b1;
    for (int i = 0; i < int'(NSLOT); i++) begin
      k_c = k_c + KW'(!slot_nop[i]);
    end
    for (int i = 1; i < int'(NSLOT); i++) begin
      if (slot_nop[i-1] && !slot_nop[i]) order_ok_c = 1'b0;
    end
  end

  assign sum_c      = SW'(inst_count) + SW'(k_c);
  assign fits_c     = (32'(sum_c) <= MAX_INST);
  assign next_cnt_c = fits_c ? sum_c[CW-1:0] : CW'(MAX_INST);

  always_comb begin
    assume_ok = 1'b0;
    case (st_q)
      ST_ISSUE: assume_ok = (&slot_legal) && order_ok_c && fits_c;
      default:  assume_ok = &slot_nop;
    endcase
    if (reset) assume_ok = 1'b1;
  end

  // Issue / drain / done sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_ISSUE;
      inst_count <= '0;
      drain_cnt  <= '0;
      seq_done   <= 1'b0;
      viol_seen  <= 1'b0;
    end else begin
      if (!assume_ok) viol_seen <= 1'b1;
      case (st_q)
        ST_ISSUE: begin
          if (inst_accept) begin
            inst_count <= next_cnt_c;
            if (32'(next_cnt_c) == MAX_INST) begin
              st_q      <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == CW'(DRAIN_CYC - 1)) begin
            st_q     <= ST_DONE;
            seq_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        ST_DONE:  seq_done <= 1'b1;
        default:  st_q <= ST_ISSUE;
      endcase
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_inst_seq_constraint.sv
// Scoreboard bench for inst_seq_constraint: two parameterisations, expectations queued at drive time.
module tb_inst_seq_constraint;

  localparam logic [31:0] W_NOP   = 32'h0000007F;
  localparam logic [31:0] W_ADD   = 32'h003100B3;
  localparam logic [31:0] W_ADD20 = 32'h00310A33;
  localparam logic [31:0] W_ADDI  = 32'h00100293;
  localparam logic [31:0] W_MUL   = 32'h023100B3;
  localparam logic [31:0] W_SLLX  = 32'h403110B3;
  localparam logic [31:0] W_LW    = 32'h00002083;
  localparam logic [31:0] W_ZERO  = 32'h00000000;

  localparam int S_OK = 0, S_LEGAL = 1, S_NOP = 2, S_STATE = 3;
  localparam int S_CNT = 4, S_DRAIN = 5, S_DONE = 6, S_VIOL = 7;
  localparam int B_OFS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, acc_a, rst_b, acc_b;
  logic [63:0] ins_a, ins_b;
  logic [1:0]  legal_a, nop_a, st_a, legal_b, nop_b, st_b;
  logic        ok_a, done_a, viol_a, ok_b, done_b, viol_b;
  logic [7:0]  cnt_a, drn_a, cnt_b, drn_b;

  inst_seq_constraint #(
    .NSLOT(2), .MAX_INST(1), .DRAIN_CYC(4), .REG_LIMIT(32), .EN_MUL(1'b1), .EN_MEM(1'b1)
  ) u_a (
    .clk(clk), .reset(rst_a), .instruction(ins_a), .inst_accept(acc_a),
    .slot_legal(legal_a), .slot_nop(nop_a), .assume_ok(ok_a), .state(st_a),
    .inst_count(cnt_a), .drain_cnt(drn_a), .seq_done(done_a), .viol_seen(viol_a)
  );

  inst_seq_constraint #(
    .NSLOT(2), .MAX_INST(3), .DRAIN_CYC(4), .REG_LIMIT(16), .EN_MUL(1'b0), .EN_MEM(1'b0)
  ) u_b (
    .clk(clk), .reset(rst_b), .instruction(ins_b), .inst_accept(acc_b),
    .slot_legal(legal_b), .slot_nop(nop_b), .assume_ok(ok_b), .state(st_b),
    .inst_count(cnt_b), .drain_cnt(drn_b), .seq_done(done_b), .viol_seen(viol_b)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_OK:            return 32'(ok_a);
      S_LEGAL:         return 32'(legal_a);
      S_NOP:           return 32'(nop_a);
      S_STATE:         return 32'(st_a);
      S_CNT:           return 32'(cnt_a);
      S_DRAIN:         return 32'(drn_a);
      S_DONE:          return 32'(done_a);
      S_VIOL:          return 32'(viol_a);
      B_OFS + S_OK:    return 32'(ok_b);
      B_OFS + S_LEGAL: return 32'(legal_b);
      B_OFS + S_NOP:   return 32'(nop_b);
      B_OFS + S_STATE: return 32'(st_b);
      B_OFS + S_CNT:   return 32'(cnt_b);
      B_OFS + S_DRAIN: return 32'(drn_b);
      B_OFS + S_DONE:  return 32'(done_b);
      B_OFS + S_VIOL:  return 32'(viol_b);
      default:         return 32'hDEADBEEF;
    endcase
  endfunction

  // off=0: combinational result this cycle; off=1: registered result after the next edge
  task automatic expect_at(input int off, input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.due = cyc + off;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  end

  task automatic drv_a(input logic r, input logic [31:0] w0, input logic [31:0] w1, input logic acc);
    rst_a = r; ins_a = {w1, w0}; acc_a = acc;
  endtask

  task automatic drv_b(input logic r, input logic [31:0] w0, input logic [31:0] w1, input logic acc);
    rst_b = r; ins_b = {w1, w0}; acc_b = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a_reset_regs(input string tag);
    expect_at(1, S_STATE, 0, {tag, "_state"});
    expect_at(1, S_CNT,   0, {tag, "_cnt"});
    expect_at(1, S_DRAIN, 0, {tag, "_drain"});
    expect_at(1, S_DONE,  0, {tag, "_done"});
    expect_at(1, S_VIOL,  0, {tag, "_viol"});
  endtask

  logic [31:0] dec_w [4];
  logic [31:0] dec_a [4];
  logic [31:0] dec_b [4];

  initial begin
    drv_a(1'b1, W_NOP, W_NOP, 1'b0);
    drv_b(1'b1, W_NOP, W_NOP, 1'b0);
    tick();

    // DUT A: reset forces assume_ok even on garbage encodings
    drv_a(1'b1, W_ZERO, W_ZERO, 1'b1);
    expect_at(0, S_OK, 1, "a_ok_in_reset");
    exp_a_reset_regs("a_rst");
    tick();

    drv_a(1'b0, W_ADD, W_NOP, 1'b1);
    expect_at(0, S_OK, 1, "a_add_ok");
    expect_at(0, S_LEGAL, 2'b11, "a_add_legal");
    expect_at(0, S_NOP, 2'b10, "a_add_nop");
    expect_at(1, S_STATE, 1, "a_to_drain");
    expect_at(1, S_CNT, 1, "a_cnt1");
    expect_at(1, S_DRAIN, 0, "a_drain0");
    tick();

    for (int i = 0; i < 4; i++) begin
      drv_a(1'b0, W_NOP, W_NOP, 1'b0);
      expect_at(0, S_OK, 1, "a_drain_ok");
      expect_at(1, S_STATE, (i == 3) ? 2 : 1, "a_drain_state");
      expect_at(1, S_DRAIN, (i == 3) ? 3 : i + 1, "a_drain_cnt");
      expect_at(1, S_DONE, (i == 3) ? 1 : 0, "a_seq_done");
      tick();
    end

    drv_a(1'b0, W_ADDI, W_NOP, 1'b1);
    expect_at(0, S_OK, 0, "a_done_addi_ok");
    expect_at(1, S_VIOL, 1, "a_viol_set");
    expect_at(1, S_STATE, 2, "a_done_hold");
    tick();

    drv_a(1'b0, W_NOP, W_NOP, 1'b0);
    expect_at(0, S_OK, 1, "a_done_nop_ok");
    expect_at(1, S_VIOL, 1, "a_viol_sticky");
    tick();

    dec_w[0] = W_MUL;   dec_a[0] = 2'b11; dec_b[0] = 2'b10;
    dec_w[1] = W_SLLX;  dec_a[1] = 2'b10; dec_b[1] = 2'b10;
    dec_w[2] = W_ADD20; dec_a[2] = 2'b11; dec_b[2] = 2'b10;
    dec_w[3] = W_LW;    dec_a[3] = 2'b11; dec_b[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      drv_a(1'b0, dec_w[i], W_NOP, 1'b0);
      expect_at(0, S_LEGAL, dec_a[i], $sformatf("a_decode_%0h", dec_w[i]));
      tick();
    end

    // DUT A: reset mid-drain restarts the sequence and clears the sticky flag
    drv_a(1'b1, W_NOP, W_NOP, 1'b0);
    tick();
    drv_a(1'b0, W_ADD, W_NOP, 1'b1);
    expect_at(1, S_STATE, 1, "a2_to_drain");
    tick();
    drv_a(1'b0, W_ADDI, W_NOP, 1'b0);
    expect_at(0, S_OK, 0, "a2_drain_addi_ok");
    expect_at(1, S_VIOL, 1, "a2_viol_set");
    expect_at(1, S_DRAIN, 1, "a2_drain1");
    tick();
    drv_a(1'b0, W_NOP, W_NOP, 1'b0);
    expect_at(1, S_DRAIN, 2, "a2_drain2");
    tick();
    drv_a(1'b1, W_ADDI, W_ADDI, 1'b1);
    expect_at(0, S_OK, 1, "a2_ok_in_reset");
    exp_a_reset_regs("a2_rst");
    tick();
    drv_a(1'b0, W_NOP, W_NOP, 1'b0);
    tick();

    // DUT B: restricted ISA, REG_LIMIT=16, MAX_INST=3
    drv_b(1'b1, W_NOP, W_NOP, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv_b(1'b0, dec_w[i], W_NOP, 1'b0);
      expect_at(0, B_OFS + S_LEGAL, dec_b[i], $sformatf("b_decode_%0h", dec_w[i]));
      expect_at(0, B_OFS + S_OK, 0, "b_illegal_ok");
      tick();
    end
    drv_b(1'b0, W_ADD, W_NOP, 1'b0);
    expect_at(0, B_OFS + S_LEGAL, 2'b11, "b_add_legal");
    expect_at(0, B_OFS + S_OK, 1, "b_add_ok");
    tick();
    drv_b(1'b0, W_NOP, W_ADD, 1'b0);
    expect_at(0, B_OFS + S_NOP, 2'b01, "b_order_nop");
    expect_at(0, B_OFS + S_LEGAL, 2'b11, "b_order_legal");
    expect_at(0, B_OFS + S_OK, 0, "b_order_issue_ok");
    tick();

    drv_b(1'b1, W_NOP, W_NOP, 1'b0);
    expect_at(1, B_OFS + S_VIOL, 0, "b_rst_viol");
    tick();

    for (int i = 0; i < 2; i++) begin
      drv_b(1'b0, W_ADD, W_ADD, 1'b0);
      expect_at(0, B_OFS + S_OK, 1, "b_stall_ok");
      expect_at(1, B_OFS + S_CNT, 0, "b_stall_cnt");
      expect_at(1, B_OFS + S_STATE, 0, "b_stall_state");
      tick();
    end
    drv_b(1'b0, W_ADD, W_ADD, 1'b1);
    expect_at(0, B_OFS + S_OK, 1, "b_acc_ok");
    expect_at(1, B_OFS + S_CNT, 2, "b_cnt2");
    expect_at(1, B_OFS + S_STATE, 0, "b_still_issue");
    tick();
    drv_b(1'b0, W_ADD, W_ADD, 1'b1);
    expect_at(0, B_OFS + S_OK, 0, "b_over_ok");
    expect_at(1, B_OFS + S_CNT, 3, "b_cnt_sat");
    expect_at(1, B_OFS + S_STATE, 1, "b_to_drain");
    expect_at(1, B_OFS + S_VIOL, 1, "b_viol_set");
    tick();
    drv_b(1'b0, W_NOP, W_ADD, 1'b0);
    expect_at(0, B_OFS + S_OK, 0, "b_drain_order_ok");
    expect_at(1, B_OFS + S_DRAIN, 1, "b_drain1");
    tick();
    drv_b(1'b0, W_NOP, W_NOP, 1'b0);
    expect_at(0, B_OFS + S_OK, 1, "b_drain_nop_ok");
    tick();

    tick();
    tick();
    check_eq("scoreboard_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
